// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the FIFO read-port arbiter: consumer count,
// FIFO read latency and the scheduler state encoding.
package fifo_arb_pkg;

   localparam int NUM_REQ = 2;
   localparam int RD_LAT  = 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker: a lone requester wins outright, a tie goes
// to the consumer that was not granted last.
module rr_arb2
   import fifo_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic               last_gnt,
   input  logic               enable,
   output logic [NUM_REQ-1:0] pick
);

   always_comb begin
      pick = '0;
      if (enable) begin
         case (req)
            2'b01:   pick = 2'b01;
            2'b10:   pick = 2'b10;
            2'b11:   pick = last_gnt ? 2'b01 : 2'b10;
            default: pick = '0;
         endcase
      end
   end

endmodule

// File: rtl/fifo_rd_arb.sv
// Read-side scheduler for the shared FIFO: grants fixed-length bursts to two
// consumers in round-robin order and steers the returned words with one-hot valids.
module fifo_rd_arb
   import fifo_arb_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int CNT_W     = 9,
   parameter int BURST_LEN = 16
) (
   input  logic               clk_50M,
   input  logic               rst_n,
   input  logic [CNT_W-1:0]   fifo_rd_count,
   input  logic               fifo_empty,
   input  logic [DATA_W-1:0]  fifo_rd_data,
   output logic               fifo_rd_en,
   input  logic [NUM_REQ-1:0] req,
   output logic [NUM_REQ-1:0] gnt,
   output logic [DATA_W-1:0]  dout,
   output logic [NUM_REQ-1:0] dout_vld,
   output logic [NUM_REQ-1:0] burst_done
);

   localparam int                BEAT_W    = $clog2(BURST_LEN + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
   localparam logic [CNT_W-1:0]  MIN_COUNT = CNT_W'(BURST_LEN);

   state_t               state, state_nxt;
   logic [NUM_REQ-1:0]   gnt_nxt;
   logic [NUM_REQ-1:0]   pick;
   logic [BEAT_W-1:0]    beat_cnt, beat_nxt;
   logic                 last_gnt, last_nxt;
   logic [RD_LAT-1:0]    rd_en_sr;
   logic                 arb_en;

   // A burst may only start once the FIFO already holds every word of it.
   assign arb_en = (state == IDLE) && (req != '0) && (fifo_rd_count >= MIN_COUNT);

   rr_arb2 u_rr_arb2 (
      .req      (req),
      .last_gnt (last_gnt),
      .enable   (arb_en),
      .pick     (pick)
   );

   assign fifo_rd_en = (state == READ) && !fifo_empty;
   assign dout       = fifo_rd_data;
   assign dout_vld   = gnt & {NUM_REQ{rd_en_sr[RD_LAT-1]}};
   assign burst_done = (state == DONE) ? gnt : '0;

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case statement can leave one unassigned and infer a latch.
      state_nxt = state;
      gnt_nxt   = gnt;
      beat_nxt  = beat_cnt;
      last_nxt  = last_gnt;
      case (state)
         IDLE: begin
            if (pick != '0) begin
               gnt_nxt   = pick;
               beat_nxt  = '0;
               state_nxt = READ;
            end
         end
         READ: begin
            // Empty cycles stall the burst; only issued reads advance it.
            if (fifo_rd_en) begin
               beat_nxt = beat_cnt + 1'b1;
               if (beat_cnt == LAST_BEAT) state_nxt = DRAIN;
            end
         end
         DRAIN: state_nxt = DONE;
         DONE: begin
            last_nxt  = gnt[1];
            gnt_nxt   = '0;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: state is updated with non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         gnt      <= '0;
         beat_cnt <= '0;
         last_gnt <= 1'b1;
         rd_en_sr <= '0;
      end else begin
         state    <= state_nxt;
         gnt      <= gnt_nxt;
         beat_cnt <= beat_nxt;
         last_gnt <= last_nxt;
         rd_en_sr <= RD_LAT'({rd_en_sr, fifo_rd_en});
      end
   end

endmodule

// File: tb/tb_fifo_rd_arb.sv
// Bench for fifo_rd_arb: directed and randomized bursts scored against a
// transaction-level model of grant order, burst length, timing and data.
module tb_fifo_rd_arb;

   localparam int BL = 16;

   logic       clk_50M = 1'b0;
   logic       rst_n;
   logic [8:0] fifo_rd_count;
   logic       fifo_empty;
   logic [7:0] fifo_rd_data;
   logic       fifo_rd_en;
   logic [1:0] req, gnt, dout_vld, burst_done;
   logic [7:0] dout;

   logic [8:0] fifo_rd_count_b;
   logic       fifo_empty_b;
   logic [7:0] fifo_rd_data_b;
   logic       fifo_rd_en_b;
   logic [1:0] req_b, gnt_b, dout_vld_b, burst_done_b;
   logic [7:0] dout_b;

   int         checks = 0;
   int         errors = 0;
   int         cyc_cnt = 0;
   int         model_last = 1;
   logic [7:0] rd_word = 8'd0;
   logic [7:0] rd_word_b = 8'd0;
   logic [7:0] exp_q[$];

   fifo_rd_arb #(.DATA_W(8), .CNT_W(9), .BURST_LEN(BL)) u_dut (
      .clk_50M       (clk_50M),
      .rst_n         (rst_n),
      .fifo_rd_count (fifo_rd_count),
      .fifo_empty    (fifo_empty),
      .fifo_rd_data  (fifo_rd_data),
      .fifo_rd_en    (fifo_rd_en),
      .req           (req),
      .gnt           (gnt),
      .dout          (dout),
      .dout_vld      (dout_vld),
      .burst_done    (burst_done)
   );

   fifo_rd_arb #(.DATA_W(8), .CNT_W(9), .BURST_LEN(1)) u_dut_b1 (
      .clk_50M       (clk_50M),
      .rst_n         (rst_n),
      .fifo_rd_count (fifo_rd_count_b),
      .fifo_empty    (fifo_empty_b),
      .fifo_rd_data  (fifo_rd_data_b),
      .fifo_rd_en    (fifo_rd_en_b),
      .req           (req_b),
      .gnt           (gnt_b),
      .dout          (dout_b),
      .dout_vld      (dout_vld_b),
      .burst_done    (burst_done_b)
   );

   always #10 clk_50M = ~clk_50M;

   // FIFO models: each read returns the next word of a counting sequence.
   always @(posedge clk_50M) begin
      cyc_cnt++;
      if (fifo_rd_en) begin
         fifo_rd_data = rd_word;
         exp_q.push_back(rd_word);
         rd_word++;
      end
      if (fifo_rd_en_b) begin
         fifo_rd_data_b = rd_word_b;
         rd_word_b++;
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [1:0] rr_model(input logic [1:0] r, input int last);
      if (r == 2'b11) return (last == 1) ? 2'b01 : 2'b10;
      return r;
   endfunction

   task automatic sample();
      @(negedge clk_50M);
      #1;
   endtask

   task automatic wait_gnt(input int max, output int lat);
      lat = -1;
      for (int i = 1; i <= max; i++) begin
         sample();
         if (gnt != 2'b00) begin
            lat = i;
            break;
         end
      end
   endtask

   // Entered in the first granted cycle; follows the burst until gnt drops.
   task automatic run_burst(input logic [1:0] exp_g, input int stall_at, input int stall_len,
                            input logic [1:0] req_after, input string tag);
      int n = 0, reads = 0, vlds = 0, dones = 0, bad = 0;
      int first_rd = -1, last_rd = -1, left;
      logic [7:0] w;
      left = stall_len;
      while (gnt != 2'b00 && n < 200) begin
         if (gnt !== exp_g) bad++;
         if (fifo_rd_en) begin
            if (fifo_empty) bad++;
            if (first_rd < 0) first_rd = n;
            last_rd = n;
            reads++;
         end
         if (dout_vld != 2'b00) begin
            vlds++;
            if (dout_vld !== exp_g) bad++;
            if (exp_q.size() == 0) bad++;
            else begin
               w = exp_q.pop_front();
               if (dout !== w) bad++;
            end
         end
         if (burst_done != 2'b00) begin
            dones++;
            if (burst_done !== exp_g) bad++;
            req = req_after;
         end
         n++;
         @(negedge clk_50M);
         if (reads == stall_at && left > 0) begin
            fifo_empty = 1'b1;
            left--;
         end else begin
            fifo_empty = 1'b0;
         end
         #1;
      end
      check({tag, "_reads"}, reads, BL);
      check({tag, "_vlds"}, vlds, BL);
      check({tag, "_done_pulses"}, dones, 1);
      check({tag, "_bad_cycles"}, bad, 0);
      check({tag, "_first_read"}, first_rd, 0);
      check({tag, "_read_span"}, last_rd - first_rd + 1, BL + stall_len);
      check({tag, "_gnt_cycles"}, n, BL + 2 + stall_len);
      model_last = (exp_g == 2'b10) ? 1 : 0;
      fifo_empty = 1'b0;
   endtask

   initial begin
      int         lat, idle_bad, start, sa, sl, lastb;
      logic [1:0] r, e, w;
      int         bad_g, bad_rd, bad_vld, bad_done, bad_dat;

      rst_n = 1'b0;
      req = 2'b00;
      fifo_rd_count = '0;
      fifo_empty = 1'b1;
      req_b = 2'b00;
      fifo_rd_count_b = '0;
      fifo_empty_b = 1'b1;
      repeat (2) sample();
      check("rst_gnt", gnt, 2'b00);
      check("rst_dout_vld", dout_vld, 2'b00);
      check("rst_burst_done", burst_done, 2'b00);
      check("rst_rd_en", fifo_rd_en, 1'b0);
      check("rst_gnt_b1", gnt_b, 2'b00);

      // Single requester after reset, counting data 0..15.
      @(negedge clk_50M);
      rst_n = 1'b1;
      fifo_empty = 1'b0;
      fifo_rd_count = 9'd20;
      req = 2'b01;
      #1;
      wait_gnt(5, lat);
      check("t1_latency", lat, 1);
      check("t1_gnt", gnt, 2'b01);
      if (lat > 0) run_burst(2'b01, 0, 0, 2'b00, "t1");

      // Count one below the threshold holds off the grant.
      req = 2'b10;
      fifo_rd_count = 9'd15;
      idle_bad = 0;
      repeat (8) begin
         sample();
         if (gnt != 2'b00 || fifo_rd_en) idle_bad++;
      end
      check("t3_below_threshold", idle_bad, 0);
      fifo_rd_count = 9'd16;
      wait_gnt(5, lat);
      check("t3_latency", lat, 1);
      check("t3_gnt", gnt, 2'b10);
      if (lat > 0) run_burst(2'b10, 0, 0, 2'b00, "t3");

      // Three empty cycles at beat 5.
      req = 2'b01;
      fifo_rd_count = 9'($urandom_range(16, 511));
      wait_gnt(5, lat);
      check("t4_gnt", gnt, rr_model(2'b01, model_last));
      if (lat > 0) run_burst(2'b01, 5, 3, 2'b00, "t4");

      // Asynchronous reset during beat 8.
      req = 2'b10;
      fifo_rd_count = 9'd30;
      wait_gnt(5, lat);
      check("t5_gnt", gnt, 2'b10);
      repeat (8) sample();
      check("t5_beat8_rd_en", fifo_rd_en, 1'b1);
      check("t5_beat8_vld", dout_vld, 2'b10);
      #2 rst_n = 1'b0;
      #1;
      check("t5_async_gnt", gnt, 2'b00);
      check("t5_async_vld", dout_vld, 2'b00);
      check("t5_async_rd_en", fifo_rd_en, 1'b0);
      check("t5_async_done", burst_done, 2'b00);
      repeat (2) @(negedge clk_50M);
      rst_n = 1'b1;
      exp_q.delete();
      model_last = 1;
      req = 2'b11;
      fifo_rd_count = 9'($urandom_range(48, 511));
      #1;

      // Both requesting: order 0,1,0 at BURST_LEN+3 cycle spacing.
      start = 0;
      for (int k = 0; k < 3; k++) begin
         e = rr_model(2'b11, model_last);
         wait_gnt(5, lat);
         check($sformatf("rr%0d_latency", k), lat, 1);
         check($sformatf("rr%0d_gnt", k), gnt, e);
         if (k > 0) check($sformatf("rr%0d_spacing", k), cyc_cnt - start, BL + 3);
         start = cyc_cnt;
         if (lat > 0) run_burst(e, 0, 0, 2'b11, $sformatf("rr%0d", k));
      end
      req = 2'b00;

      // Random requests, counts and stalls.
      for (int it = 0; it < 6; it++) begin
         r = 2'($urandom_range(1, 3));
         sa = $urandom_range(1, BL - 1);
         sl = $urandom_range(0, 4);
         req = r;
         fifo_empty = 1'b0;
         fifo_rd_count = 9'($urandom_range(16, 511));
         e = rr_model(r, model_last);
         wait_gnt(5, lat);
         check($sformatf("rnd%0d_gnt", it), gnt, e);
         if (lat > 0) run_burst(e, sa, sl, 2'b00, $sformatf("rnd%0d", it));
      end

      // BURST_LEN=1 instance: READ, DRAIN, DONE, IDLE repeating every 4 cycles.
      req_b = 2'b11;
      fifo_rd_count_b = 9'd3;
      fifo_empty_b = 1'b0;
      lastb = 1;
      w = 2'b00;
      bad_g = 0; bad_rd = 0; bad_vld = 0; bad_done = 0; bad_dat = 0;
      for (int c = 1; c <= 12; c++) begin
         sample();
         if ((c - 1) % 4 == 0) w = rr_model(2'b11, lastb);
         if (gnt_b !== (((c - 1) % 4 < 3) ? w : 2'b00)) bad_g++;
         if (fifo_rd_en_b !== ((c - 1) % 4 == 0)) bad_rd++;
         if (dout_vld_b !== (((c - 1) % 4 == 1) ? w : 2'b00)) bad_vld++;
         if (burst_done_b !== (((c - 1) % 4 == 2) ? w : 2'b00)) bad_done++;
         if (dout_vld_b != 2'b00 && dout_b !== rd_word_b - 8'd1) bad_dat++;
         if ((c - 1) % 4 == 2) lastb = (w == 2'b10) ? 1 : 0;
      end
      req_b = 2'b00;
      check("b1_gnt_pattern", bad_g, 0);
      check("b1_rd_en_pattern", bad_rd, 0);
      check("b1_vld_pattern", bad_vld, 0);
      check("b1_done_pattern", bad_done, 0);
      check("b1_data", bad_dat, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
